// File: rtl/my_div.sv
// my_div: iterative radix-2 restoring divider for DIV/DIVU.
// One quotient bit per clock, then a sign/divide-by-zero fix-up cycle,
// then a one-cycle ready pulse. Result is {remainder, quotient}.
//
// Handshake: start is accepted only when the FSM is in IDLE and annul is
// low. busy is high from the cycle after the accept through the ready cycle.
// ready is a single-cycle pulse, and result is valid while ready is high.
// result then holds its value until the next completed FIX cycle. annul
// squashes any in-flight operation and suppresses its ready pulse.
module my_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sign,
  input  logic               start,
  input  logic               annul,
  output logic               busy,
  output logic               ready,
  output logic [2*WIDTH-1:0] result,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_a_orig;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_div0;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_trial;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  // Operand conditioning. Magnitudes are taken only for signed ops, and
  // -MIN wraps back to MIN, which is exactly the unsigned magnitude 2^(W-1).
  assign w_accept = (r_state == S_IDLE) && start && !annul;
  assign w_a_neg  = sign && a[WIDTH-1];
  assign w_b_neg  = sign && b[WIDTH-1];
  assign w_a_abs  = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_abs  = w_b_neg ? (~b + 1'b1) : b;

  // One restoring step. The shifted partial remainder needs W+1 bits.
  // When it is >= divisor the difference is < divisor, so W bits hold it.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});
  assign w_trial  = w_rem_sh[WIDTH-1:0] - r_div;

  // Fix-up: the quotient truncates toward zero and the remainder follows
  // the dividend's sign. Divide-by-zero returns all-ones and the raw dividend.
  assign w_q_fix = r_div0 ? {WIDTH{1'b1}} : (r_sign_q ? (~r_quo + 1'b1) : r_quo);
  assign w_r_fix = r_div0 ? r_a_orig : (r_sign_r ? (~r_rem + 1'b1) : r_rem);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic. annul returns any busy state to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      S_CALC: begin
        if (annul)                 w_next = S_IDLE;
        else if (r_cnt == CNT_LAST) w_next = S_FIX;
      end
      S_FIX:  w_next = annul ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then iterate, then register the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_a_orig <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_rem    <= '0;
        r_quo    <= w_a_abs;
        r_div    <= w_b_abs;
        r_a_orig <= a;
        r_sign_q <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_sign_r <= w_a_neg;
        r_div0   <= (b == '0);
        r_cnt    <= '0;
      end else if ((r_state == S_CALC) && !annul) begin
        r_rem <= w_ge ? w_trial : w_rem_sh[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
        r_cnt <= r_cnt + CW'(1);
      end
      if ((r_state == S_FIX) && !annul) begin
        r_result <= {w_r_fix, w_q_fix};
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign ready     = (r_state == S_DONE) && !annul;
  assign result    = r_result;
  assign dbg_state = r_state;

endmodule
